// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR        : encoding placed in IF/ID for a bubble
//   DEFAULT_RESET_PC : default PC value after reset
//   fetch_state_e    : fetch FSM states
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'b0;
   localparam int unsigned DEFAULT_RESET_PC = 0;

   typedef enum logic [1:0] {
      StWarmup = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings (hazard unit, ROM, decode).
//   master : fetch-stage side (drives rom_addr and the IF/ID outputs)
//   slave  : environment side (drives control inputs and ROM read data)
// Signals:
//   stall, flush, redirect_valid, redirect_pc, halt_req : pipeline control
//   rom_addr / rom_data                                   : instruction ROM port
//   if_instr, if_pc, if_valid                             : IF/ID register contents
//   halted, fetch_count                                   : status / debug
interface fetch_stage_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12
);

   logic                     stall;
   logic                     flush;
   logic                     redirect_valid;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     halt_req;
   logic [ADDRESS_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0]    rom_data;
   logic [DATA_WIDTH-1:0]    if_instr;
   logic [ADDRESS_WIDTH-1:0] if_pc;
   logic                     if_valid;
   logic                     halted;
   logic [31:0]              fetch_count;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, halt_req, rom_data,
      output rom_addr, if_instr, if_pc, if_valid, halted, fetch_count
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, halt_req, rom_data,
      input  rom_addr, if_instr, if_pc, if_valid, halted, fetch_count
   );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program-counter register for the fetch stage.
//   clk, reset : clock, asynchronous active-high reset (loads RESET_PC)
//   load_i     : load load_pc_i (highest priority)
//   inc_i      : increment by one, wrapping at 2^ADDRESS_WIDTH
//   pc_o       : current PC
// With neither load_i nor inc_i the PC holds.
module fetch_stage_pc_register #(
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned RESET_PC      = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_i,
   input  logic [ADDRESS_WIDTH-1:0] load_pc_i,
   input  logic                     inc_i,
   output logic [ADDRESS_WIDTH-1:0] pc_o
);

   logic [ADDRESS_WIDTH-1:0] pc_d;
   logic [ADDRESS_WIDTH-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDRESS_WIDTH'(1);  // natural wrap at the top of the address space
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= ADDRESS_WIDTH'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// captures the ROM's negedge read data into the IF/ID register on the posedge.
//   clk   : single clock (ROM reads on its negedge, this block uses posedge)
//   reset : asynchronous, active-high
//   bus   : fetch_stage_if master modport (control in, ROM port, IF/ID out)
// rom_addr is a direct wire from the PC; all other outputs are registered.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned RESET_PC      = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   fetch_state_e             state_q;
   logic [ADDRESS_WIDTH-1:0] pc;
   logic                     pc_load;
   logic                     pc_inc;
   logic [DATA_WIDTH-1:0]    if_instr_q;
   logic [ADDRESS_WIDTH-1:0] if_pc_q;
   logic                     if_valid_q;
   logic                     halted_q;
   logic [31:0]              fetch_count_q;

   // pc_inc doubles as the "capture a new instruction" condition.
   always_comb begin
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      unique case (state_q)
         StRun: begin
            pc_load = bus.redirect_valid;
            pc_inc  = !bus.redirect_valid && !bus.halt_req && !bus.flush && !bus.stall;
         end
         StHalted: begin
            pc_load = bus.redirect_valid;
         end
         default: ;
      endcase
   end

   fetch_stage_pc_register #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RESET_PC      (RESET_PC)
   ) u_pc_register (
      .clk       (clk),
      .reset     (reset),
      .load_i    (pc_load),
      .load_pc_i (bus.redirect_pc),
      .inc_i     (pc_inc),
      .pc_o      (pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StWarmup;
         if_instr_q    <= DATA_WIDTH'(NOP_INSTR);
         if_pc_q       <= '0;
         if_valid_q    <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         unique case (state_q)
            // One idle edge so the ROM completes a negedge read at RESET_PC first.
            StWarmup: begin
               state_q <= StRun;
            end
            StRun: begin
               if (bus.redirect_valid || bus.halt_req || bus.flush) begin
                  // Bubble; if_pc keeps its previous value.
                  if_instr_q <= DATA_WIDTH'(NOP_INSTR);
                  if_valid_q <= 1'b0;
                  if (!bus.redirect_valid && bus.halt_req) begin
                     state_q  <= StHalted;
                     halted_q <= 1'b1;
                  end
               end else if (!bus.stall) begin
                  if_instr_q    <= bus.rom_data;
                  if_pc_q       <= pc;
                  if_valid_q    <= 1'b1;
                  fetch_count_q <= fetch_count_q + 32'd1;
               end
            end
            StHalted: begin
               // IF/ID is already a bubble; only a redirect wakes the stage.
               if (bus.redirect_valid) begin
                  state_q  <= StRun;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StWarmup;
            end
         endcase
      end
   end

   assign bus.rom_addr    = pc;
   assign bus.if_instr    = if_instr_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.halted      = halted_q;
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle vectors plus
// hand-written reset sequences.
module tb_fetch_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;

   logic clk;
   logic reset;

   fetch_stage_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   fetch_stage #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .RESET_PC      (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic          stall;
      logic          flush;
      logic          rv;
      logic [AW-1:0] rpc;
      logic          halt;
      logic          ev;
      logic [DW-1:0] ei;
      logic [AW-1:0] epc;
      logic [AW-1:0] eaddr;
      logic [31:0]   ecnt;
      logic          eh;
   } vec_t;

   vec_t        vecs[$];
   logic [DW-1:0] rom [4096];
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: registered read on negedge.
   always @(negedge clk) bus.rom_data <= rom[bus.rom_addr];

   function automatic logic [31:0] romv(input int i);
      return 32'hA500_0000 | 32'(i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic add(input logic st, input logic fl, input logic rv, input logic [AW-1:0] rpc,
                      input logic hl, input logic ev, input logic [DW-1:0] ei,
                      input logic [AW-1:0] epc, input logic [AW-1:0] eaddr,
                      input logic [31:0] ecnt, input logic eh);
      vec_t v;
      v.stall = st; v.flush = fl; v.rv = rv; v.rpc = rpc; v.halt = hl;
      v.ev = ev; v.ei = ei; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt; v.eh = eh;
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input logic ev, input logic [DW-1:0] ei,
                                input logic [AW-1:0] epc, input logic [AW-1:0] eaddr,
                                input logic [31:0] ecnt, input logic eh);
      check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(ev));
      check({tag, ".if_instr"}, bus.if_instr, ei);
      check({tag, ".if_pc"}, 32'(bus.if_pc), 32'(epc));
      check({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(eaddr));
      check({tag, ".fetch_count"}, bus.fetch_count, ecnt);
      check({tag, ".halted"}, 32'(bus.halted), 32'(eh));
   endtask

   task automatic set_idle();
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0; bus.halt_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = romv(i);

      // st fl rv rpc    hl | ev ei            epc     eaddr   cnt eh
      add(0, 0, 0, 0,      0,  0, 0,            0,      0,      0,  0); // warmup edge
      add(0, 0, 0, 0,      0,  1, romv(0),      0,      1,      1,  0); // A
      add(0, 0, 0, 0,      0,  1, romv(1),      1,      2,      2,  0); // B
      add(1, 0, 0, 0,      0,  1, romv(1),      1,      2,      2,  0); // stall
      add(1, 0, 0, 0,      0,  1, romv(1),      1,      2,      2,  0); // stall
      add(0, 0, 0, 0,      0,  1, romv(2),      2,      3,      3,  0); // C
      add(0, 0, 0, 0,      0,  1, romv(3),      3,      4,      4,  0);
      add(0, 0, 0, 0,      0,  1, romv(4),      4,      5,      5,  0);
      add(1, 0, 1, 'h100,  0,  0, 0,            4,      'h100,  5,  0); // redirect beats stall
      add(0, 0, 0, 0,      0,  1, romv('h100),  'h100,  'h101,  6,  0);
      add(1, 1, 0, 0,      0,  0, 0,            'h100,  'h101,  6,  0); // flush beats stall
      add(0, 0, 0, 0,      0,  1, romv('h101),  'h101,  'h102,  7,  0);
      add(0, 0, 1, 'hFFF,  0,  0, 0,            'h101,  'hFFF,  7,  0);
      add(0, 0, 0, 0,      0,  1, romv('hFFF),  'hFFF,  0,      8,  0); // PC wraps
      add(0, 0, 0, 0,      0,  1, romv(0),      0,      1,      9,  0);
      add(0, 0, 1, 7,      0,  0, 0,            0,      7,      9,  0);
      add(0, 0, 0, 0,      1,  0, 0,            0,      7,      9,  1); // halt at PC=7
      for (int i = 0; i < 10; i++) begin
         add(i[0], i[1], 0, 0, (i == 3), 0, 0, 0, 7, 9, 1);          // frozen while halted
      end
      add(0, 0, 1, 'h20,   0,  0, 0,            0,      'h20,   9,  0); // resume
      add(0, 0, 0, 0,      0,  1, romv('h20),   'h20,   'h21,   10, 0);
      add(0, 0, 0, 0,      0,  1, romv('h21),   'h21,   'h22,   11, 0);
      add(0, 0, 1, 9,      0,  0, 0,            'h21,   9,      11, 0); // PC=9

      set_idle();
      reset = 1'b0;
      #1 reset = 1'b1;
      #1 check_outputs("reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.stall          = vecs[i].stall;
         bus.flush          = vecs[i].flush;
         bus.redirect_valid = vecs[i].rv;
         bus.redirect_pc    = vecs[i].rpc;
         bus.halt_req       = vecs[i].halt;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].epc,
                       vecs[i].eaddr, vecs[i].ecnt, vecs[i].eh);
      end

      // Asynchronous reset mid-cycle while running at PC=9.
      set_idle();
      #2 reset = 1'b1;
      #1 check_outputs("async_reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 check_outputs("post_reset_warmup", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 check_outputs("post_reset_first", 1, romv(0), 0, 1, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
